// File: rtl/sfifo_prm.sv
// -----------------------------------------------------------------------------
// sfifo_prm -- parameterised single-clock synchronous FIFO
//
// Stores up to DEPTH words of WIDTH bits in a circular buffer addressed by
// two log2(DEPTH)-bit pointers. The output stage works in one of two modes:
//   FWFT = 0 : registered read, dout loads the head entry on an accepted read
//   FWFT = 1 : first-word-fall-through, dout always shows the head entry
// All status flags are registered and derived from the next-state count, so
// they always agree with `count` in the same cycle.
//
// Ports
//   clk          in   clock, all state changes on the rising edge
//   rst          in   synchronous active-low reset
//   w_en         in   write request
//   din          in   write data [WIDTH]
//   r_en         in   read request (FWFT=0) / pop (FWFT=1)
//   dout         out  read data [WIDTH]
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AF_LEVEL
//   almost_empty out  count <= AE_LEVEL
//   count        out  occupancy 0..DEPTH [$clog2(DEPTH)+1]
//   overflow     out  one-cycle pulse after a rejected write
//   underflow    out  one-cycle pulse after a rejected read
// -----------------------------------------------------------------------------
module sfifo_prm #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 64,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     r_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_af;
    logic             r_ae;
    logic             r_ovf;
    logic             r_udf;
    logic [WIDTH-1:0] r_dout;

    logic             w_wr_ok;
    logic             w_rd_ok;
    logic [AW-1:0]    w_rptr_nxt;
    logic [CW-1:0]    w_count_nxt;

    // A write into a full FIFO is still accepted when a read frees the slot
    // in the same cycle; a read of an empty FIFO is never accepted, so a
    // concurrent write cannot be bypassed straight to the reader.
    // NOTE: every signal driven from always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_rd_ok     = r_en & ~r_empty;
        w_wr_ok     = w_en & (~r_full | r_en);
        w_rptr_nxt  = w_rd_ok ? r_rptr + AW'(1) : r_rptr;
        w_count_nxt = r_count;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // NOTE: the storage array has no reset; after reset the pointers and
    // count say it is empty, so its stale contents are never observed.
    always_ff @(posedge clk) begin
        if (rst && w_wr_ok) begin
            r_mem[r_wptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            r_af    <= (w_count_nxt >= CW'(AF_LEVEL));
            r_ae    <= (w_count_nxt <= CW'(AE_LEVEL));
            r_ovf   <= w_en & r_full & ~r_en;
            r_udf   <= r_en & r_empty;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            logic w_head_bypass;

            // The next head is the word being written this cycle when no
            // stored entry remains after the (optional) pop; memory is not
            // yet updated at that edge, so take it from din directly.
            always_comb begin
                w_head_bypass = w_wr_ok & (r_count == CW'(w_rd_ok));
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_dout <= '0;
                end else if (w_count_nxt != '0) begin
                    r_dout <= w_head_bypass ? din : r_mem[w_rptr_nxt];
                end
            end
        end else begin : g_reg
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_dout <= '0;
                end else if (w_rd_ok) begin
                    r_dout <= r_mem[r_rptr];
                end
            end
        end
    endgenerate

    assign dout         = r_dout;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule

// File: tb/tb_sfifo_prm.sv
// -----------------------------------------------------------------------------
// tb_sfifo_prm -- directed bench for sfifo_prm at default geometry.
// Two instances share one stimulus: u_reg (FWFT=0) and u_fwft (FWFT=1).
// A short vector table covers basic read/write/reset behaviour, followed by
// hand-written sequences for fill/overflow, drain/underflow, full-depth
// simultaneous traffic, mid-operation reset and fall-through output.
// -----------------------------------------------------------------------------
module tb_sfifo_prm;

    localparam int DEPTH = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          w_en;
    logic [7:0]    din;
    logic          r_en;

    logic [7:0]    dout,   f_dout;
    logic          full,   f_full;
    logic          empty,  f_empty;
    logic          af,     f_af;
    logic          ae,     f_ae;
    logic [CW-1:0] count,  f_count;
    logic          ovf,    f_ovf;
    logic          udf,    f_udf;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sfifo_prm #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(0)) u_reg (
        .clk(clk), .rst(rst), .w_en(w_en), .din(din), .r_en(r_en),
        .dout(dout), .full(full), .empty(empty), .almost_full(af),
        .almost_empty(ae), .count(count), .overflow(ovf), .underflow(udf)
    );

    sfifo_prm #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .w_en(w_en), .din(din), .r_en(r_en),
        .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_udf)
    );

    typedef struct {
        logic       rst_n;
        logic       w;
        logic [7:0] d;
        logic       r;
        int         exp_count;
        logic       exp_ovf;
        logic       exp_udf;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic step(input logic rs, input logic w, input logic [7:0] d, input logic r);
        rst  = rs;
        w_en = w;
        din  = d;
        r_en = r;
        @(posedge clk);
        #1;
    endtask

    // Flag model at default thresholds: AF_LEVEL = 60, AE_LEVEL = 4.
    task automatic check_level(input string name, input int exp_count);
        check({name, " count"}, int'(count), exp_count);
        check({name, " empty"}, int'(empty), int'(exp_count == 0));
        check({name, " full"},  int'(full),  int'(exp_count == DEPTH));
        check({name, " af"},    int'(af),    int'(exp_count >= 60));
        check({name, " ae"},    int'(ae),    int'(exp_count <= 4));
    endtask

    initial begin
        int n_ovf;
        int exp;

        rst = 1'b0; w_en = 1'b0; din = '0; r_en = 1'b0;

        vecs[0]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 8'h22, 1'b0, 2, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 8'h11};
        vecs[3]  = '{1'b1, 1'b1, 8'h33, 1'b1, 1, 1'b0, 1'b0, 8'h22};
        vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 8'h33};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 8'h33};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 8'h33};
        vecs[7]  = '{1'b1, 1'b1, 8'h44, 1'b1, 1, 1'b0, 1'b1, 8'h33};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 8'h33};
        vecs[9]  = '{1'b0, 1'b1, 8'h55, 1'b0, 0, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{1'b1, 1'b1, 8'h66, 1'b0, 1, 1'b0, 1'b0, 8'h00};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 8'h66};

        // Reset state
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
        check_level("reset", 0);
        check("reset ovf",    int'(ovf),    0);
        check("reset udf",    int'(udf),    0);
        check("reset dout",   int'(dout),   0);
        check("reset f_dout", int'(f_dout), 0);

        // Basic vector table
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst_n, vecs[i].w, vecs[i].d, vecs[i].r);
            check_level($sformatf("vec%0d", i), vecs[i].exp_count);
            check($sformatf("vec%0d ovf", i),  int'(ovf),  int'(vecs[i].exp_ovf));
            check($sformatf("vec%0d udf", i),  int'(udf),  int'(vecs[i].exp_udf));
            check($sformatf("vec%0d dout", i), int'(dout), int'(vecs[i].exp_dout));
        end

        // Fill with 100 writes: 64 accepted, 36 overflow pulses, thresholds
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
        n_ovf = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b1, 8'(100 + i), 1'b0);
            check_level($sformatf("fill%0d", i), (i < 64) ? i + 1 : 64);
            check($sformatf("fill%0d ovf", i), int'(ovf), int'(i >= 64));
            if (ovf) n_ovf++;
        end
        check("overflow pulse total", n_ovf, 36);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("ovf after idle", int'(ovf), 0);

        // Drain to empty: registered dout 100..163, fall-through head ahead
        for (int i = 0; i < 64; i++) begin
            check($sformatf("drain%0d f_dout", i), int'(f_dout), 100 + i);
            step(1'b1, 1'b0, 8'h00, 1'b1);
            check($sformatf("drain%0d dout", i), int'(dout), 100 + i);
            check_level($sformatf("drain%0d", i), 63 - i);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("empty read udf",    int'(udf),   1);
        check("empty read f_udf",  int'(f_udf), 1);
        check("empty read dout",   int'(dout),  163);
        check("empty read count",  int'(count), 0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("udf after idle",    int'(udf),   0);

        // Refill, then simultaneous read/write at full depth
        for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 8'(100 + i), 1'b0);
        check_level("refill", 64);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 8'(200 + i), 1'b1);
            check_level($sformatf("rw_full%0d", i), 64);
            check($sformatf("rw_full%0d ovf", i),    int'(ovf),    0);
            check($sformatf("rw_full%0d dout", i),   int'(dout),   100 + i);
            check($sformatf("rw_full%0d f_dout", i), int'(f_dout), 101 + i);
        end
        for (int i = 0; i < 64; i++) begin
            exp = (i < 54) ? 110 + i : 200 + (i - 54);
            check($sformatf("drain2_%0d f_dout", i), int'(f_dout), exp);
            step(1'b1, 1'b0, 8'h00, 1'b1);
            check($sformatf("drain2_%0d dout", i), int'(dout), exp);
        end
        check_level("drain2 end", 0);

        // Reset at count 37 with a concurrent write
        for (int i = 0; i < 37; i++) step(1'b1, 1'b1, 8'(i), 1'b0);
        check_level("pre-reset", 37);
        check("pre-reset dout", int'(dout), 209);
        step(1'b0, 1'b1, 8'hEE, 1'b0);
        check_level("mid reset", 0);
        check("mid reset ovf",  int'(ovf),  0);
        check("mid reset udf",  int'(udf),  0);
        check("mid reset dout", int'(dout), 0);
        step(1'b1, 1'b1, 8'h77, 1'b0);
        check_level("post-reset write", 1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("post-reset read dout", int'(dout), 8'h77);
        check_level("post-reset read", 0);

        // Fall-through mode sequences
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
        check("fwft reset dout", int'(f_dout), 0);
        step(1'b1, 1'b1, 8'hA5, 1'b0);
        check("fwft A5 empty", int'(f_empty), 0);
        check("fwft A5 dout",  int'(f_dout),  8'hA5);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("fwft pop empty", int'(f_empty), 1);
        check("fwft pop hold",  int'(f_dout),  8'hA5);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("fwft idle hold", int'(f_dout),  8'hA5);
        step(1'b1, 1'b1, 8'h01, 1'b0);
        check("fwft w1 dout", int'(f_dout), 8'h01);
        step(1'b1, 1'b1, 8'h02, 1'b0);
        check("fwft w2 dout", int'(f_dout), 8'h01);
        step(1'b1, 1'b1, 8'h03, 1'b0);
        check("fwft w3 dout",  int'(f_dout),  8'h01);
        check("fwft w3 count", int'(f_count), 3);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("fwft r1 dout", int'(f_dout), 8'h02);
        step(1'b1, 1'b1, 8'h04, 1'b1);
        check("fwft rw dout",  int'(f_dout),  8'h03);
        check("fwft rw count", int'(f_count), 2);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("fwft r2 dout", int'(f_dout), 8'h04);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("fwft r3 empty", int'(f_empty), 1);
        check("fwft r3 hold",  int'(f_dout),  8'h04);
        step(1'b1, 1'b1, 8'h10, 1'b1);
        check("fwft empty rw udf",   int'(f_udf),   1);
        check("fwft empty rw count", int'(f_count), 1);
        check("fwft empty rw dout",  int'(f_dout),  8'h10);
        step(1'b1, 1'b1, 8'h20, 1'b1);
        check("fwft rw1 count", int'(f_count), 1);
        check("fwft rw1 empty", int'(f_empty), 0);
        check("fwft rw1 dout",  int'(f_dout),  8'h20);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("fwft last empty", int'(f_empty), 1);
        check("fwft last hold",  int'(f_dout),  8'h20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
